pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the branch-decision unit.
- Holds PC and EPC and selects next PC from: sequential PC+4 (ALU output), branch-resolved address, jump target, or EPC on return-from-exception.
- Runs a multi-cycle exception-entry sequence. It saves EPC, reads the handler address byte from memory, and loads that byte into PC.
- Sits between the control unit, the branch unit output, and the memory address mux.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value after reset
EPC_OFFSET, 32'd4, subtracted from PC when saving EPC (PC already incremented at fetch)
EXC_BASE, 32'd253, memory byte address of the handler-vector table
MEM_LATENCY, 1, cycles from exc_mem_read assertion to valid mem_rdata (1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_write  input  1  load next PC this cycle (RUN only)
pc_src  input  2  00 alu_in, 01 brancher_in, 10 jump target, 11 epc (rte)
alu_in  input  32  PC+4 from ALU
brancher_in  input  32  branch-resolved next PC
jump_index  input  26  instruction [25:0]
exc_req  input  1  exception request, sampled in RUN
exc_code  input  2  00 invalid opcode, 01 overflow, 10 divide by zero, 11 reserved (treated as 00)
mem_rdata  input  8  byte returned by memory
pc_out  output  32  current PC
epc_out  output  32  exception PC
exc_addr_out  output  32  vector byte address driven to memory mux
exc_mem_read  output  1  memory read strobe during exception fetch
busy  output  1  high whenever state != RUN
exc_done  output  1  one-cycle pulse when handler address loaded

Behaviour:
- Reset (async, any state): pc_out=RESET_VECTOR, epc_out=0, exc_addr_out=0, exc_mem_read=0, busy=0, exc_done=0, state=RUN, latency counter=0.
- Jump target = {pc_out[31:28], jump_index, 2'b00}. Computed from the current pc_out.
- States: RUN, EXC_ADDR, EXC_WAIT, EXC_LOAD.
- RUN:
  - exc_req=1 → epc_out <= pc_out - EPC_OFFSET (32-bit modular, wraps). exc_addr_out <= EXC_BASE + code (code 11 maps to 0). Go to EXC_ADDR. pc_out unchanged.
  - exc_req has priority over a simultaneous pc_write; the pc_write is discarded.
  - Otherwise, if pc_write=1, pc_out <= selected source on the next edge. pc_write=0 holds pc_out.
- EXC_ADDR: exc_mem_read=1, counter <= MEM_LATENCY-1. If MEM_LATENCY=1, go to EXC_LOAD; else go to EXC_WAIT.
- EXC_WAIT: exc_mem_read=1. Counter decrements each cycle. At 1, go to EXC_LOAD.
- EXC_LOAD:
  - pc_out <= {24'b0, mem_rdata}. exc_mem_read=0.
  - exc_done=1 for exactly the cycle after the load edge (registered).
  - Return to RUN.
- exc_mem_read, exc_addr_out and busy are registered and change only on clock edges.
- Latency:
  - PC update: 1 edge after pc_write.
  - Exception entry: exc_req edge to new PC = MEM_LATENCY+2 edges.
- While busy: pc_write, pc_src and exc_req are ignored, with no queuing. epc_out is frozen until the next exception entry.
- rte (pc_src=11 with pc_write): pc_out <= epc_out. epc_out is unchanged.
- A reset asserted mid-exception aborts the sequence. Nothing is partially committed after reset release.
- exc_addr_out holds its last value after returning to RUN.

Test Plan:
- Reset, then 3 cycles with pc_write=1, pc_src=00, alu_in=pc_out+4 → pc_out = 0, 4, 8, 12; busy=0; epc_out=0.
- pc_out=0x0000_0010, pc_src=01, brancher_in=0x0000_0040, pc_write=1 → pc_out=0x40 next edge. Then pc_src=10, jump_index=26'h0000100 → pc_out=0x0000_0400.
- pc_out=0x0000_0024, exc_req=1, exc_code=01, MEM_LATENCY=1, mem_rdata=0x7C → epc_out=0x20, exc_addr_out=254, exc_mem_read high 1 cycle, pc_out=0x7C after 3 edges, exc_done single pulse. Then rte → pc_out=0x20.
- exc_req=1 and pc_write=1 (pc_src=01) in the same cycle → exception taken, pc_out not loaded from brancher_in. exc_req pulses while busy → ignored, epc_out unchanged.
- pc_out=0, exc_code=11, MEM_LATENCY=3 → epc_out=0xFFFF_FFFC, exc_addr_out=253, exc_mem_read high 3 cycles, pc_out loaded after 5 edges.
- reset asserted in EXC_WAIT → all outputs at reset values immediately (async). After release, pc_write operates normally from RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds PC/EPC, selects the next PC and runs the
// multi-cycle exception entry that fetches the handler address byte from memory.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EPC_OFFSET   = 32'd4,
  parameter logic [31:0] EXC_BASE     = 32'd253,
  parameter int unsigned MEM_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_in,
  input  logic [31:0] brancher_in,
  input  logic [25:0] jump_index,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic [31:0] exc_addr_out,
  output logic        exc_mem_read,
  output logic        busy,
  output logic        exc_done
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] SRC_ALU    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_EPC    = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_EXC_ADDR = 2'b01,
    ST_EXC_WAIT = 2'b10,
    ST_EXC_LOAD = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      exc_addr_q, exc_addr_d;
  logic             mem_read_q, mem_read_d;
  logic             busy_q, busy_d;
  logic             exc_done_q, exc_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      jump_target;
  logic [31:0]      next_pc;
  logic [1:0]       code_eff;

  // Next-PC source mux; jump target keeps the current PC's top nibble.
  always_comb begin
    jump_target = {pc_q[31:28], jump_index, 2'b00};
    next_pc     = alu_in;
    unique case (pc_src)
      SRC_ALU:    next_pc = alu_in;
      SRC_BRANCH: next_pc = brancher_in;
      SRC_JUMP:   next_pc = jump_target;
      SRC_EPC:    next_pc = epc_q;
      default:    next_pc = alu_in;
    endcase
  end

  // Reserved code 11 vectors like invalid opcode.
  assign code_eff = (exc_code == 2'b11) ? 2'b00 : exc_code;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    exc_addr_d = exc_addr_q;
    cnt_d      = cnt_q;
    mem_read_d = 1'b0;
    exc_done_d = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (exc_req) begin
          epc_d      = pc_q - EPC_OFFSET;
          exc_addr_d = EXC_BASE + 32'(code_eff);
          mem_read_d = 1'b1;
          state_d    = ST_EXC_ADDR;
        end else if (pc_write) begin
          pc_d = next_pc;
        end
      end
      ST_EXC_ADDR: begin
        cnt_d = LAT_LOAD;
        if (LAT_LOAD == '0) begin
          state_d = ST_EXC_LOAD;
        end else begin
          mem_read_d = 1'b1;
          state_d    = ST_EXC_WAIT;
        end
      end
      ST_EXC_WAIT: begin
        // A zero count can only come from a bad parameter; never stall on it.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_EXC_LOAD;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          mem_read_d = 1'b1;
        end
      end
      ST_EXC_LOAD: begin
        pc_d       = {24'b0, mem_rdata};
        exc_done_d = 1'b1;
        state_d    = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      exc_addr_q <= '0;
      mem_read_q <= 1'b0;
      busy_q     <= 1'b0;
      exc_done_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      exc_addr_q <= exc_addr_d;
      mem_read_q <= mem_read_d;
      busy_q     <= busy_d;
      exc_done_q <= exc_done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_out       = pc_q;
  assign epc_out      = epc_q;
  assign exc_addr_out = exc_addr_q;
  assign exc_mem_read = mem_read_q;
  assign busy         = busy_q;
  assign exc_done     = exc_done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: one instance with single-cycle memory
// latency, one with three-cycle latency.
module tb_pc_sequencer;

  typedef struct {
    int unsigned cyc;
    bit          dut_b;
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] addr;
    logic        rd;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned cycle = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  logic        a_pw = 1'b0, b_pw = 1'b0;
  logic [1:0]  a_src = 2'b00, b_src = 2'b00;
  logic [31:0] a_alu = '0, b_alu = '0;
  logic [31:0] a_br = '0, b_br = '0;
  logic [25:0] a_ji = '0, b_ji = '0;
  logic        a_er = 1'b0, b_er = 1'b0;
  logic [1:0]  a_ec = 2'b00, b_ec = 2'b00;
  logic [7:0]  a_md = '0, b_md = '0;

  logic [31:0] a_pc, a_epc, a_addr, b_pc, b_epc, b_addr;
  logic        a_rd, a_busy, a_done, b_rd, b_busy, b_done;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  pc_sequencer #(.MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .pc_write(a_pw), .pc_src(a_src),
    .alu_in(a_alu), .brancher_in(a_br), .jump_index(a_ji),
    .exc_req(a_er), .exc_code(a_ec), .mem_rdata(a_md),
    .pc_out(a_pc), .epc_out(a_epc), .exc_addr_out(a_addr),
    .exc_mem_read(a_rd), .busy(a_busy), .exc_done(a_done)
  );

  pc_sequencer #(.MEM_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset), .pc_write(b_pw), .pc_src(b_src),
    .alu_in(b_alu), .brancher_in(b_br), .jump_index(b_ji),
    .exc_req(b_er), .exc_code(b_ec), .mem_rdata(b_md),
    .pc_out(b_pc), .epc_out(b_epc), .exc_addr_out(b_addr),
    .exc_mem_read(b_rd), .busy(b_busy), .exc_done(b_done)
  );

  function automatic void check(input exp_t e);
    logic [31:0] pc, epc, addr;
    logic rd, bsy, dn;
    pc   = e.dut_b ? b_pc   : a_pc;
    epc  = e.dut_b ? b_epc  : a_epc;
    addr = e.dut_b ? b_addr : a_addr;
    rd   = e.dut_b ? b_rd   : a_rd;
    bsy  = e.dut_b ? b_busy : a_busy;
    dn   = e.dut_b ? b_done : a_done;
    n_checks++;
    if (pc !== e.pc || epc !== e.epc || addr !== e.addr ||
        rd !== e.rd || bsy !== e.busy || dn !== e.done) begin
      n_fail++;
      $display("FAIL %s: got pc=%h epc=%h addr=%h rd=%b busy=%b done=%b, want pc=%h epc=%h addr=%h rd=%b busy=%b done=%b",
               e.name, pc, epc, addr, rd, bsy, dn, e.pc, e.epc, e.addr, e.rd, e.busy, e.done);
    end
  endfunction

  task automatic expect_nxt(input bit b, input string name, input logic [31:0] pc,
                            input logic [31:0] epc, input logic [31:0] addr,
                            input logic rd, input logic bsy, input logic dn);
    exp_t e;
    e.cyc = cycle + 1; e.dut_b = b; e.name = name;
    e.pc = pc; e.epc = epc; e.addr = addr; e.rd = rd; e.busy = bsy; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic sa(input logic pw, input logic [1:0] src, input logic [31:0] alu,
                    input logic [31:0] br, input logic [25:0] ji, input logic er,
                    input logic [1:0] ec, input logic [7:0] md, input string name,
                    input logic [31:0] pc, input logic [31:0] epc, input logic [31:0] addr,
                    input logic rd, input logic bsy, input logic dn);
    a_pw = pw; a_src = src; a_alu = alu; a_br = br; a_ji = ji;
    a_er = er; a_ec = ec; a_md = md;
    expect_nxt(1'b0, name, pc, epc, addr, rd, bsy, dn);
    @(negedge clk);
  endtask

  task automatic sb(input logic pw, input logic [31:0] alu, input logic er,
                    input logic [1:0] ec, input logic [7:0] md, input string name,
                    input logic [31:0] pc, input logic [31:0] epc, input logic [31:0] addr,
                    input logic rd, input logic bsy, input logic dn);
    b_pw = pw; b_src = 2'b00; b_alu = alu; b_er = er; b_ec = ec; b_md = md;
    expect_nxt(1'b1, name, pc, epc, addr, rd, bsy, dn);
    @(negedge clk);
  endtask

  // Monitor: compare every expectation that falls due on this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
        e = exp_q.pop_front();
        if (e.cyc < cycle) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: stale expectation for cycle %0d, now %0d", e.name, e.cyc, cycle);
        end else begin
          check(e);
        end
      end
    end
  end

  initial begin
    exp_t z;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_nxt(1'b1, "b_reset_state", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'h00, "a_reset_state", 32'h0, 32'h0, 32'h0, 0, 0, 0);

    sa(1, 2'd0, 32'd4,  32'h0, 26'h0, 0, 2'd0, 8'h00, "seq_4",  32'd4,  32'h0, 32'h0, 0, 0, 0);
    sa(1, 2'd0, 32'd8,  32'h0, 26'h0, 0, 2'd0, 8'h00, "seq_8",  32'd8,  32'h0, 32'h0, 0, 0, 0);
    sa(1, 2'd0, 32'd12, 32'h0, 26'h0, 0, 2'd0, 8'h00, "seq_12", 32'd12, 32'h0, 32'h0, 0, 0, 0);
    sa(1, 2'd0, 32'h10, 32'h0, 26'h0, 0, 2'd0, 8'h00, "seq_10", 32'h10, 32'h0, 32'h0, 0, 0, 0);
    sa(1, 2'd1, 32'h0, 32'h40, 26'h0, 0, 2'd0, 8'h00, "branch", 32'h40, 32'h0, 32'h0, 0, 0, 0);
    sa(1, 2'd2, 32'h0, 32'h0, 26'h0000100, 0, 2'd0, 8'h00, "jump", 32'h400, 32'h0, 32'h0, 0, 0, 0);
    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'h00, "hold", 32'h400, 32'h0, 32'h0, 0, 0, 0);
    sa(1, 2'd0, 32'h24, 32'h0, 26'h0, 0, 2'd0, 8'h00, "seq_24", 32'h24, 32'h0, 32'h0, 0, 0, 0);

    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 1, 2'd1, 8'h00, "exc1_addr", 32'h24, 32'h20, 32'd254, 1, 1, 0);
    sa(1, 2'd1, 32'h0, 32'h999, 26'h0, 1, 2'd2, 8'h7C, "exc1_load", 32'h24, 32'h20, 32'd254, 0, 1, 0);
    sa(1, 2'd1, 32'h0, 32'h999, 26'h0, 1, 2'd2, 8'h7C, "exc1_done", 32'h7C, 32'h20, 32'd254, 0, 0, 1);
    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'h00, "exc1_pulse_end", 32'h7C, 32'h20, 32'd254, 0, 0, 0);
    sa(1, 2'd3, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'h00, "rte", 32'h20, 32'h20, 32'd254, 0, 0, 0);

    sa(1, 2'd1, 32'h0, 32'h1234, 26'h0, 1, 2'd0, 8'h00, "exc_prio_addr", 32'h20, 32'h1C, 32'd253, 1, 1, 0);
    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'h55, "exc_prio_load", 32'h20, 32'h1C, 32'd253, 0, 1, 0);
    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'h55, "exc_prio_done", 32'h55, 32'h1C, 32'd253, 0, 0, 1);

    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 1, 2'd2, 8'h00, "exc_div_addr", 32'h55, 32'h51, 32'd255, 1, 1, 0);
    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'hAB, "exc_div_load", 32'h55, 32'h51, 32'd255, 0, 1, 0);
    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'hAB, "exc_div_done", 32'hAB, 32'h51, 32'd255, 0, 0, 1);

    sa(1, 2'd0, 32'hA000_0000, 32'h0, 26'h0, 0, 2'd0, 8'h00, "seq_hi", 32'hA000_0000, 32'h51, 32'd255, 0, 0, 0);
    sa(1, 2'd2, 32'h0, 32'h0, 26'h3FF_FFFF, 0, 2'd0, 8'h00, "jump_hi", 32'hAFFF_FFFC, 32'h51, 32'd255, 0, 0, 0);
    sa(0, 2'd0, 32'h0, 32'h0, 26'h0, 0, 2'd0, 8'h00, "jump_hi_hold", 32'hAFFF_FFFC, 32'h51, 32'd255, 0, 0, 0);

    sb(0, 32'h0, 1, 2'd3, 8'h00, "b_exc_addr",  32'h0, 32'hFFFF_FFFC, 32'd253, 1, 1, 0);
    sb(0, 32'h0, 0, 2'd0, 8'h00, "b_exc_wait1", 32'h0, 32'hFFFF_FFFC, 32'd253, 1, 1, 0);
    sb(0, 32'h0, 0, 2'd0, 8'h00, "b_exc_wait2", 32'h0, 32'hFFFF_FFFC, 32'd253, 1, 1, 0);
    sb(0, 32'h0, 0, 2'd0, 8'hC8, "b_exc_load",  32'h0, 32'hFFFF_FFFC, 32'd253, 0, 1, 0);
    sb(0, 32'h0, 0, 2'd0, 8'hC8, "b_exc_done",  32'hC8, 32'hFFFF_FFFC, 32'd253, 0, 0, 1);
    sb(0, 32'h0, 0, 2'd0, 8'h00, "b_pulse_end", 32'hC8, 32'hFFFF_FFFC, 32'd253, 0, 0, 0);
    sb(1, 32'h30, 0, 2'd0, 8'h00, "b_seq_30",   32'h30, 32'hFFFF_FFFC, 32'd253, 0, 0, 0);
    sb(0, 32'h0, 1, 2'd1, 8'hEE, "b_exc2_addr", 32'h30, 32'h2C, 32'd254, 1, 1, 0);
    sb(0, 32'h0, 0, 2'd0, 8'hEE, "b_exc2_wait", 32'h30, 32'h2C, 32'd254, 1, 1, 0);

    // Asynchronous reset in the middle of the wait phase.
    reset = 1'b1;
    #1;
    z.cyc = cycle; z.dut_b = 1'b1; z.name = "b_async_reset";
    z.pc = 32'h0; z.epc = 32'h0; z.addr = 32'h0; z.rd = 1'b0; z.busy = 1'b0; z.done = 1'b0;
    check(z);
    z.dut_b = 1'b0; z.name = "a_async_reset";
    check(z);
    @(negedge clk);
    reset = 1'b0;
    expect_nxt(1'b0, "a_after_reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    sb(1, 32'd4, 0, 2'd0, 8'hEE, "b_after_reset", 32'd4, 32'h0, 32'h0, 0, 0, 0);
    sb(0, 32'h0, 0, 2'd0, 8'hEE, "b_after_reset_hold", 32'd4, 32'h0, 32'h0, 0, 0, 0);

    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      z = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", z.name, z.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
